// File: rtl/exc_commit_seq.sv
// exc_commit_seq: commit-side exception / ERET sequencer.
// Accepts one exception or ERET from in-order commit and applies the
// architectural CP0 updates one register per cycle through CP0's exception
// write port. It then issues a one-cycle flush plus a redirect to fetch.
// Every output is registered. The output values for a state are computed on
// the same edge that enters that state, so they are visible for exactly that
// state's cycle.
module exc_commit_seq #(
    parameter logic [31:0] BEV_BASE   = 32'hBFC00200,
    parameter logic [31:0] GEN_OFFSET = 32'h00000180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic        exc_has_badva,
    input  logic [31:0] exc_badva,
    input  logic        eret_valid,
    output logic        req_ready,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    input  logic [31:0] cp0_ebase,
    input  logic [31:0] cp0_errorepc,
    output logic        cp0_we,
    output logic [4:0]  cp0_addr,
    output logic [2:0]  cp0_sel,
    output logic [31:0] cp0_wdata,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_BADVA  = 3'd1,
        S_W_EPC    = 3'd2,
        S_W_CAUSE  = 3'd3,
        S_W_STATUS = 3'd4,
        S_E_STATUS = 3'd5,
        S_REDIR    = 3'd6
    } state_t;

    localparam logic [4:0] ADDR_BADVA  = 5'd8;
    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    // EPC points at the branch when the faulting instruction sits in its delay slot.
    function automatic logic [31:0] epc_value(input logic [31:0] pc, input logic bd);
        logic [31:0] r;
        if (bd) begin
            r = pc - 32'd4;
        end else begin
            r = pc;
        end
        return r;
    endfunction

    // New Cause: ExcCode replaced; BD only updated on a first-level exception.
    function automatic logic [31:0] cause_value(input logic [31:0] cause, input logic [4:0] code,
                                                input logic bd, input logic exl);
        logic [31:0] r;
        r      = cause;
        r[6:2] = code;
        if (exl) begin
            r[31] = cause[31];
        end else begin
            r[31] = bd;
        end
        return r;
    endfunction

    // General-exception vector; low 12 bits of EBase are not part of the base.
    function automatic logic [31:0] exc_vector(input logic [31:0] status, input logic [31:0] ebase);
        logic [31:0] base;
        if (status[22]) begin
            base = BEV_BASE;
        end else begin
            base = ebase & 32'hFFFFF000;
        end
        return base + GEN_OFFSET;
    endfunction

    // ERET returns from the error level first (ERL), otherwise from EXL.
    function automatic logic [31:0] eret_status(input logic [31:0] status);
        logic [31:0] r;
        r = status;
        if (status[2]) begin
            r[2] = 1'b0;
        end else begin
            r[1] = 1'b0;
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        flush_q, flush_d;
    logic        rv_q, rv_d;
    logic [31:0] rpc_q, rpc_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;

    logic [4:0]  s_code_q, s_code_d;
    logic [31:0] s_pc_q, s_pc_d;
    logic        s_bd_q, s_bd_d;
    logic [31:0] s_status_q, s_status_d;
    logic [31:0] s_cause_q, s_cause_d;
    logic [31:0] s_ebase_q, s_ebase_d;
    logic [31:0] s_epc_q, s_epc_d;
    logic [31:0] s_errorepc_q, s_errorepc_d;

    // Next-state, next-output and snapshot capture logic.
    always_comb begin
        state_d      = state_q;
        we_d         = 1'b0;
        addr_d       = 5'd0;
        wdata_d      = 32'd0;
        flush_d      = 1'b0;
        rv_d         = 1'b0;
        rpc_d        = 32'd0;
        ready_d      = 1'b0;
        s_code_d     = s_code_q;
        s_pc_d       = s_pc_q;
        s_bd_d       = s_bd_q;
        s_status_d   = s_status_q;
        s_cause_d    = s_cause_q;
        s_ebase_d    = s_ebase_q;
        s_epc_d      = s_epc_q;
        s_errorepc_d = s_errorepc_q;

        case (state_q)
            S_IDLE: begin
                if (exc_valid) begin
                    s_code_d   = exc_code;
                    s_pc_d     = exc_pc;
                    s_bd_d     = exc_bd;
                    s_status_d = cp0_status;
                    s_cause_d  = cp0_cause;
                    s_ebase_d  = cp0_ebase;
                    if (exc_has_badva) begin
                        state_d = S_W_BADVA;
                        we_d    = 1'b1;
                        addr_d  = ADDR_BADVA;
                        wdata_d = exc_badva;
                    end else begin
                        // EPC is preserved when already at exception level.
                        state_d = S_W_EPC;
                        we_d    = ~cp0_status[1];
                        addr_d  = ADDR_EPC;
                        wdata_d = epc_value(exc_pc, exc_bd);
                    end
                end else if (eret_valid) begin
                    s_status_d   = cp0_status;
                    s_epc_d      = cp0_epc;
                    s_errorepc_d = cp0_errorepc;
                    state_d      = S_E_STATUS;
                    we_d         = 1'b1;
                    addr_d       = ADDR_STATUS;
                    wdata_d      = eret_status(cp0_status);
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_W_BADVA: begin
                state_d = S_W_EPC;
                we_d    = ~s_status_q[1];
                addr_d  = ADDR_EPC;
                wdata_d = epc_value(s_pc_q, s_bd_q);
            end
            S_W_EPC: begin
                state_d = S_W_CAUSE;
                we_d    = 1'b1;
                addr_d  = ADDR_CAUSE;
                wdata_d = cause_value(s_cause_q, s_code_q, s_bd_q, s_status_q[1]);
            end
            S_W_CAUSE: begin
                state_d = S_W_STATUS;
                we_d    = 1'b1;
                addr_d  = ADDR_STATUS;
                wdata_d = s_status_q | 32'h00000002;
            end
            S_W_STATUS: begin
                state_d = S_REDIR;
                flush_d = 1'b1;
                rv_d    = 1'b1;
                rpc_d   = exc_vector(s_status_q, s_ebase_q);
            end
            S_E_STATUS: begin
                state_d = S_REDIR;
                flush_d = 1'b1;
                rv_d    = 1'b1;
                if (s_status_q[2]) begin
                    rpc_d = s_errorepc_q;
                end else begin
                    rpc_d = s_epc_q;
                end
            end
            S_REDIR: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase

        busy_d = ~ready_d;
    end

    // State, registered outputs and snapshot registers; reset returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            addr_q       <= 5'd0;
            wdata_q      <= 32'd0;
            flush_q      <= 1'b0;
            rv_q         <= 1'b0;
            rpc_q        <= 32'd0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            s_code_q     <= 5'd0;
            s_pc_q       <= 32'd0;
            s_bd_q       <= 1'b0;
            s_status_q   <= 32'd0;
            s_cause_q    <= 32'd0;
            s_ebase_q    <= 32'd0;
            s_epc_q      <= 32'd0;
            s_errorepc_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            flush_q      <= flush_d;
            rv_q         <= rv_d;
            rpc_q        <= rpc_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            s_code_q     <= s_code_d;
            s_pc_q       <= s_pc_d;
            s_bd_q       <= s_bd_d;
            s_status_q   <= s_status_d;
            s_cause_q    <= s_cause_d;
            s_ebase_q    <= s_ebase_d;
            s_epc_q      <= s_epc_d;
            s_errorepc_q <= s_errorepc_d;
        end
    end

    assign cp0_we         = we_q;
    assign cp0_addr       = addr_q;
    assign cp0_sel        = 3'b000;
    assign cp0_wdata      = wdata_q;
    assign flush          = flush_q;
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;
    assign req_ready      = ready_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_exc_commit_seq.sv
// Self-checking bench for exc_commit_seq: a vector table of exceptions and
// ERETs with hand-computed CP0 writes and redirect targets. Each vector
// expands into a per-cycle expected-output queue that is compared cycle by
// cycle. Hand-written sequences cover reset, including reset in mid-sequence.
module tb_exc_commit_seq;

    logic        clk;
    logic        rst;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        exc_has_badva;
    logic [31:0] exc_badva;
    logic        eret_valid;
    logic        req_ready;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_ebase;
    logic [31:0] cp0_errorepc;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [2:0]  cp0_sel;
    logic [31:0] cp0_wdata;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    exc_commit_seq dut (
        .clk            (clk),
        .rst            (rst),
        .exc_valid      (exc_valid),
        .exc_code       (exc_code),
        .exc_pc         (exc_pc),
        .exc_bd         (exc_bd),
        .exc_has_badva  (exc_has_badva),
        .exc_badva      (exc_badva),
        .eret_valid     (eret_valid),
        .req_ready      (req_ready),
        .cp0_status     (cp0_status),
        .cp0_cause      (cp0_cause),
        .cp0_epc        (cp0_epc),
        .cp0_ebase      (cp0_ebase),
        .cp0_errorepc   (cp0_errorepc),
        .cp0_we         (cp0_we),
        .cp0_addr       (cp0_addr),
        .cp0_sel        (cp0_sel),
        .cp0_wdata      (cp0_wdata),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_eret;
        logic        both;
        logic        noise;
        logic        hb;
        logic        bd;
        logic [4:0]  code;
        logic [31:0] pc;
        logic [31:0] badva;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] ebase;
        logic [31:0] errorepc;
        logic        e_epc_we;
        logic [31:0] e_badva;
        logic [31:0] e_epc;
        logic [31:0] e_cause;
        logic [31:0] e_status;
        logic [31:0] e_rpc;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[7];
    int   n_cmp;
    int   n_bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic void push_e(input logic we, input logic [4:0] a, input logic [31:0] d,
                                   input logic redir, input logic [31:0] rpc, input logic rdy);
        exp_t e;
        e.we    = we;
        e.addr  = a;
        e.wdata = d;
        e.redir = redir;
        e.rpc   = rpc;
        e.rdy   = rdy;
        sb_q.push_back(e);
    endfunction

    task automatic cmp_cycle(input string tag);
        exp_t e;
        n_cmp = n_cmp + 1;
        if (sb_q.size() == 0) begin
            n_bad = n_bad + 1;
            $display("FAIL %s.queue: got empty expected an entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".we"}, {31'd0, cp0_we}, {31'd0, e.we});
            if (e.we) begin
                chk({tag, ".addr"}, {27'd0, cp0_addr}, {27'd0, e.addr});
                chk({tag, ".wdata"}, cp0_wdata, e.wdata);
            end
            chk({tag, ".flush"}, {31'd0, flush}, {31'd0, e.redir});
            chk({tag, ".rv"}, {31'd0, redirect_valid}, {31'd0, e.redir});
            if (e.redir) begin
                chk({tag, ".rpc"}, redirect_pc, e.rpc);
            end
            chk({tag, ".ready"}, {31'd0, req_ready}, {31'd0, e.rdy});
            chk({tag, ".busy"}, {31'd0, busy}, {31'd0, ~e.rdy});
            chk({tag, ".sel"}, {29'd0, cp0_sel}, 32'd0);
        end
    endtask

    task automatic drive_idle();
        exc_valid     = 1'b0;
        eret_valid    = 1'b0;
        exc_code      = 5'd0;
        exc_pc        = 32'd0;
        exc_bd        = 1'b0;
        exc_has_badva = 1'b0;
        exc_badva     = 32'd0;
        cp0_status    = 32'd0;
        cp0_cause     = 32'd0;
        cp0_epc       = 32'd0;
        cp0_ebase     = 32'd0;
        cp0_errorepc  = 32'd0;
    endtask

    task automatic drive_vec(input vec_t v);
        exc_valid     = ~v.is_eret;
        eret_valid    = v.is_eret | v.both;
        exc_code      = v.code;
        exc_pc        = v.pc;
        exc_bd        = v.bd;
        exc_has_badva = v.hb;
        exc_badva     = v.badva;
        cp0_status    = v.status;
        cp0_cause     = v.cause;
        cp0_epc       = v.epc;
        cp0_ebase     = v.ebase;
        cp0_errorepc  = v.errorepc;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int k;
        @(negedge clk);
        drive_vec(v);
        if (v.is_eret) begin
            push_e(1'b1, 5'd12, v.e_status, 1'b0, 32'd0, 1'b0);
        end else begin
            if (v.hb) begin
                push_e(1'b1, 5'd8, v.e_badva, 1'b0, 32'd0, 1'b0);
            end
            push_e(v.e_epc_we, 5'd14, v.e_epc, 1'b0, 32'd0, 1'b0);
            push_e(1'b1, 5'd13, v.e_cause, 1'b0, 32'd0, 1'b0);
            push_e(1'b1, 5'd12, v.e_status, 1'b0, 32'd0, 1'b0);
        end
        push_e(1'b0, 5'd0, 32'd0, 1'b1, v.e_rpc, 1'b0);
        push_e(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        @(posedge clk);
        #1;
        exc_valid  = 1'b0;
        eret_valid = 1'b0;
        k = 1;
        while (sb_q.size() > 0) begin
            cmp_cycle($sformatf("v%0d.c%0d", idx, k));
            if (v.noise && k == 1) begin
                exc_valid  = 1'b1;
                eret_valid = 1'b1;
                exc_code   = 5'h1F;
                exc_pc     = 32'h0;
                cp0_status = 32'hFFFFFFFF;
                cp0_cause  = 32'hFFFFFFFF;
                cp0_ebase  = 32'h12345678;
            end
            if (v.noise && k == 3) begin
                exc_valid  = 1'b0;
                eret_valid = 1'b0;
            end
            if (sb_q.size() > 0) begin
                @(posedge clk);
                #1;
            end
            k = k + 1;
        end
        drive_idle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        drive_idle();

        //             eret both noise hb bd code   pc            badva         status        cause         epc           ebase         errorepc     epcwe e_badva       e_epc         e_cause       e_status      e_rpc
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4,  32'h80001000, 32'h00000123, 32'h0040FF01, 32'h00000000, 32'h0, 32'h80000000, 32'h0, 1'b1, 32'h00000123, 32'h80001000, 32'h00000010, 32'h0040FF03, 32'hBFC00380};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  32'h80000104, 32'h0,        32'h0000FF01, 32'h00000400, 32'h0, 32'h80000000, 32'h0, 1'b1, 32'h0,        32'h80000100, 32'h80000420, 32'h0000FF03, 32'h80000180};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 32'h80000200, 32'h0,        32'h0000FF03, 32'h0000007C, 32'h0, 32'h9FC01234, 32'h0, 1'b0, 32'h0,        32'h80000200, 32'h00000028, 32'h0000FF03, 32'h9FC01180};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2,  32'h80000300, 32'hDEADBEEF, 32'h00400002, 32'h80000000, 32'h0, 32'h80000000, 32'h0, 1'b0, 32'hDEADBEEF, 32'h80000300, 32'h80000008, 32'h00400002, 32'hBFC00380};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        32'h00000003, 32'h0,        32'h80002000, 32'h0, 32'hBFC00000, 1'b0, 32'h0, 32'h0, 32'h0,   32'h00000001, 32'h80002000};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        32'h00000006, 32'h0,        32'h80002000, 32'h0, 32'hBFC00000, 1'b0, 32'h0, 32'h0, 32'h0,   32'h00000002, 32'hBFC00000};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 32'h80003000, 32'h00000456, 32'h0000FF01, 32'h00000000, 32'h12345678, 32'h80000000, 32'h0, 1'b1, 32'h00000456, 32'h80003000, 32'h00000030, 32'h0000FF03, 32'h80000180};

        // Reset state while rst is held low.
        @(posedge clk);
        #1;
        chk("rst.ready", {31'd0, req_ready}, 32'd1);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.we", {31'd0, cp0_we}, 32'd0);
        chk("rst.addr", {27'd0, cp0_addr}, 32'd0);
        chk("rst.wdata", cp0_wdata, 32'd0);
        chk("rst.flush", {31'd0, flush}, 32'd0);
        chk("rst.rv", {31'd0, redirect_valid}, 32'd0);
        chk("rst.rpc", redirect_pc, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("idle.ready", {31'd0, req_ready}, 32'd1);
        chk("idle.we", {31'd0, cp0_we}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in mid-sequence: accept an exception, then pull reset during W_EPC.
        @(negedge clk);
        drive_vec(vecs[1]);
        @(posedge clk);
        #1;
        drive_idle();
        chk("mid.we_before", {31'd0, cp0_we}, 32'd1);
        chk("mid.busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid.async_we", {31'd0, cp0_we}, 32'd0);
        chk("mid.async_ready", {31'd0, req_ready}, 32'd1);
        chk("mid.async_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("mid.ready", {31'd0, req_ready}, 32'd1);
        chk("mid.we", {31'd0, cp0_we}, 32'd0);
        chk("mid.flush", {31'd0, flush}, 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("mid.quiet%0d.we", c), {31'd0, cp0_we}, 32'd0);
            chk($sformatf("mid.quiet%0d.flush", c), {31'd0, flush}, 32'd0);
            chk($sformatf("mid.quiet%0d.ready", c), {31'd0, req_ready}, 32'd1);
        end

        // Normal operation resumes after the mid-sequence reset.
        run_vec(vecs[4], 7);
        run_vec(vecs[0], 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
